// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults and occupancy encoding for the FIFO stream reader.
package fifo_stream_reader_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int CNT_W_DFLT  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry valid/ready buffer (head + skid) that keeps beats in arrival order.
//
// state     | meaning
// OCC_EMPTY | no beat held, valid low
// OCC_ONE   | head holds the beat on offer
// OCC_TWO   | head on offer, skid holds the next beat
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] skid;

    assign valid = (occ != OCC_EMPTY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            skid <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= push_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        skid <= push_data;
                        occ  <= OCC_TWO;
                    end else if (pop) begin
                        occ <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // the skid entry is older than any arriving beat
                    if (pop) begin
                        head <= skid;
                        if (push) begin
                            skid <= push_data;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(occ == OCC_TWO && push && !pop));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the 4-entry byte FIFO: issues rd_en, absorbs the
// one-cycle read latency and presents the bytes on a valid/ready stream.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  rd_count
);

    logic       inflight;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] level;

    assign pop = m_valid && m_ready;

    // Slots committed after this edge; a new read only goes out if its data
    // is certain to find a free slot when it lands.
    assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = rstn && en && !fifo_empty && (level < 3'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_rd_en && !fifo_empty;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .valid     (m_valid),
        .head      (m_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural 4-entry FIFO in front, scoreboard
// queue filled on each FIFO write, monitor compares every accepted beat.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [CW-1:0] rd_count;

    logic          wr_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] fmem [4];
    logic [1:0]    rp, wp;
    logic [2:0]    fcnt;
    logic          do_rd, do_wr;

    logic [DW-1:0] exp_q [$];
    logic [CW-1:0] exp_cnt;
    int            n_vec = 0;
    int            n_bad = 0;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .rd_count   (rd_count)
    );

    assign fifo_empty = (fcnt == 3'd0);
    assign do_rd      = fifo_rd_en && (fcnt != 3'd0);
    assign do_wr      = wr_en && (fcnt != 3'd4);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rp        <= '0;
            wp        <= '0;
            fcnt      <= '0;
            fifo_data <= '0;
        end else begin
            if (do_rd) begin
                fifo_data <= fmem[rp];
                rp        <= rp + 2'd1;
            end
            if (do_wr) begin
                fmem[wp] <= wdata;
                wp       <= wp + 2'd1;
            end
            fcnt <= fcnt + {2'b00, do_wr} - {2'b00, do_rd};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    initial begin
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
                check("rst_m_valid", {31'd0, m_valid}, 0);
                check("rst_rd_count", {28'd0, rd_count}, 0);
            end else begin
                check("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 0);
                check("rd_count", {28'd0, rd_count}, {28'd0, exp_cnt});
                if (prev_stall) begin
                    check("hold_valid", {31'd0, m_valid}, 1);
                    check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL extra_beat: got 0x%0h, expected no beat at %0t", m_data, $time);
                    end else begin
                        check("beat", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                    end
                    exp_cnt = exp_cnt + 4'd1;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic write_byte(input logic [DW-1:0] b);
        int guard = 0;
        while (fcnt == 3'd4 && guard < 100) begin
            tick();
            guard++;
        end
        check("write_wait_timeout", (guard < 100) ? 32'd1 : 32'd0, 1);
        wr_en = 1'b1;
        wdata = b;
        exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        rstn    = 1'b0;
        en      = 1'b1;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wdata   = '0;
        exp_cnt = '0;

        // reset state, then empty FIFO with en=1
        repeat (3) begin
            @(negedge clk);
            check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
            check("rst_m_data", {24'd0, m_data}, 0);
        end
        tick();
        rstn    = 1'b1;
        m_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_rd_en", {31'd0, fifo_rd_en}, 0);
            check("idle_m_valid", {31'd0, m_valid}, 0);
            check("idle_m_data", {24'd0, m_data}, 0);
            check("idle_rd_count", {28'd0, rd_count}, 0);
        end

        // preloaded FIFO, consumer always ready: latency 2, four back-to-back beats
        tick();
        do_reset();
        en = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        en = 1'b1;
        @(negedge clk);
        check("first_rd_en", {31'd0, fifo_rd_en}, 1);
        @(negedge clk);
        check("lat_cycle1_valid", {31'd0, m_valid}, 0);
        repeat (4) begin
            @(negedge clk);
            check("burst_valid", {31'd0, m_valid}, 1);
        end
        @(negedge clk);
        check("burst_end_valid", {31'd0, m_valid}, 0);
        check("burst_rd_count", {28'd0, rd_count}, 4);

        // consumer stalled: exactly two reads accepted, head held
        tick();
        do_reset();
        en      = 1'b0;
        m_ready = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        en = 1'b1;
        repeat (6) tick();
        check("stall_rd_en", {31'd0, fifo_rd_en}, 0);
        check("stall_fifo_left", {29'd0, fcnt}, 2);
        check("stall_m_valid", {31'd0, m_valid}, 1);
        check("stall_m_data", {24'd0, m_data}, 8'h11);
        m_ready = 1'b1;
        drain();
        check("stall_rd_count", {28'd0, rd_count}, 4);

        // toggling ready with concurrent writes A0..A7
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_ready = ~m_ready;
            write_byte(8'hA0 + 8'(i));
        end
        m_ready = 1'b1;
        drain();
        check("toggle_rd_count", {28'd0, rd_count}, 8);

        // en dropped right after the first read: that beat still lands
        do_reset();
        en = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        en = 1'b1;
        @(negedge clk);
        check("en_first_rd", {31'd0, fifo_rd_en}, 1);
        tick();
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("en_off_rd_en", {31'd0, fifo_rd_en}, 0);
        end
        check("en_off_pending", exp_q.size(), 1);
        check("en_off_fifo_left", {29'd0, fcnt}, 1);
        tick();
        en = 1'b1;
        drain();

        // rd_count wrap at 2^CNT_W
        do_reset();
        for (int i = 0; i < 15; i++) write_byte(8'h60 + 8'(i));
        drain();
        check("wrap_pre", {28'd0, rd_count}, 15);
        write_byte(8'h7F);
        drain();
        check("wrap_post", {28'd0, rd_count}, 0);

        // reset while the buffer holds two beats
        do_reset();
        m_ready = 1'b0;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        repeat (5) tick();
        check("pre_rst_valid", {31'd0, m_valid}, 1);
        rstn = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        #1;
        check("midrst_m_valid", {31'd0, m_valid}, 0);
        check("midrst_m_data", {24'd0, m_data}, 0);
        check("midrst_rd_en", {31'd0, fifo_rd_en}, 0);
        tick();
        rstn    = 1'b1;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_beat", {31'd0, m_valid}, 0);
        end
        tick();
        write_byte(8'h5A);
        write_byte(8'h5B);
        drain();
        check("post_rst_rd_count", {28'd0, rd_count}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
